ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit.sv | 136 +++++++++++++
 tb/tb_ifetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the word to decode and forms the next PC from NPCOp/IMM/RA.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   - a misaligned next PC traps into S_ERR with sticky addr_err
//   undefined - next PC low bits are forced to 2'b00, addr_err tied to 0
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | dead cycle after reset, no request
// S_REQ   | imem_req high at imem_addr=pc, waiting for imem_ack
// S_VALID | instr/pc presented to decode, waiting for instr_ready
// S_ERR   | misaligned next PC trapped, no requests until rst
module ifetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [1:0]        NPCOp,
    input  logic [25:0]       IMM,
    input  logic [31:0]       RA,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [1:0] OP_PLUS4  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] p4, br_off, npc;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic addr_err_q, addr_err_d;
`endif

    // Next-PC arithmetic; wraps modulo 2^ADDR_W without any error.
    always_comb begin
        p4     = pc_q + ADDR_W'(4);
        br_off = ADDR_W'({{14{IMM[15]}}, IMM[15:0], 2'b00});
        npc    = p4;
        case (NPCOp)
            OP_PLUS4:  npc = p4;
            OP_BRANCH: npc = p4 + br_off;
            OP_JUMP: begin
                npc        = p4;
                npc[27:0]  = {IMM, 2'b00};
            end
            default:   npc = ADDR_W'(RA);
        endcase
    end

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        addr_err_d = addr_err_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (npc[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                        state_d    = S_ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = S_REQ;
                    end
`else
                    pc_d    = npc & ~ADDR_W'(3);
                    state_d = S_REQ;
`endif
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset abandons any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) addr_err_q <= 1'b0;
        else     addr_err_q <= addr_err_d;
    end
    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, stalls, wait states, all NPCOp
// kinds, misaligned JUMPR, reset mid-request and PC wrap-around.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  NPCOp;
    logic [25:0] IMM;
    logic [31:0] RA;
    logic        addr_err;

    int n_chk  = 0;
    int n_pass = 0;

    ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .NPCOp       (NPCOp),
        .IMM         (IMM),
        .RA          (RA),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the DUT to be requesting addr; holds ack off for waits cycles.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] word, input int waits);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, "_wait_req"}, 32'(imem_req), 32'd1);
            check({tag, "_wait_addr"}, imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr"}, instr, word);
        check({tag, "_pc"}, pc, addr);
        check({tag, "_req_drop"}, 32'(imem_req), 32'd0);
    endtask

    task automatic accept(input string tag, input logic [1:0] op, input logic [25:0] imm,
                          input logic [31:0] ra, input logic [31:0] exp_pc);
        instr_ready = 1'b1;
        NPCOp       = op;
        IMM         = imm;
        RA          = ra;
        tick();
        instr_ready = 1'b0;
        NPCOp       = 2'b00;
        IMM         = '0;
        RA          = '0;
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_npc"}, imem_addr, exp_pc);
        check({tag, "_err"}, 32'(addr_err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        tick();
        check({tag, "_pc"}, pc, 32'h0000_3000);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_err"}, 32'(addr_err), 32'd0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        NPCOp       = 2'b00;
        IMM         = '0;
        RA          = '0;

        // 1: reset, one dead cycle, then same-cycle ack
        do_reset("rst1");
        fetch("f3000", 32'h0000_3000, 32'h2008_0005, 0);

        // 2: stall with a stray ack that must be ignored, then sequential
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, 32'h2008_0005);
            check("stall_pc", pc, 32'h0000_3000);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        accept("seq", 2'b00, 26'd0, 32'd0, 32'h0000_3004);
        fetch("f3004", 32'h0000_3004, 32'h1111_0001, 4);
        accept("seq2", 2'b00, 26'd0, 32'd0, 32'h0000_3008);

        // 3: branch forward then backward from 0x3008
        fetch("f3008a", 32'h0000_3008, 32'h1000_0003, 1);
        accept("br_fwd", 2'b01, 26'h000_0003, 32'd0, 32'h0000_3018);
        fetch("f3018", 32'h0000_3018, 32'h0300_0008, 0);
        accept("jr3008", 2'b11, 26'd0, 32'h0000_3008, 32'h0000_3008);
        fetch("f3008b", 32'h0000_3008, 32'h1000_FFFD, 2);
        accept("br_bwd", 2'b01, 26'h000_FFFD, 32'd0, 32'h0000_3000);

        // 4: jump and jump-register
        fetch("f3000b", 32'h0000_3000, 32'h0300_3010, 0);
        accept("jr3010", 2'b11, 26'd0, 32'h0000_3010, 32'h0000_3010);
        fetch("f3010", 32'h0000_3010, 32'h0800_0C40, 0);
        accept("jump", 2'b10, 26'h000_0C40, 32'd0, 32'h0000_3100);
        fetch("f3100", 32'h0000_3100, 32'h0300_3020, 0);
        accept("jr3020", 2'b11, 26'd0, 32'h0000_3020, 32'h0000_3020);
        fetch("f3020", 32'h0000_3020, 32'h0300_3022, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        instr_ready = 1'b1;
        NPCOp       = 2'b11;
        RA          = 32'h0000_3022;
        tick();
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("err_flag", 32'(addr_err), 32'd1);
            check("err_valid", 32'(instr_valid), 32'd0);
            check("err_req", 32'(imem_req), 32'd0);
            check("err_pc", pc, 32'h0000_3020);
            tick();
        end
        imem_ack = 1'b0;
`else
        accept("jr_mis", 2'b11, 26'd0, 32'h0000_3022, 32'h0000_3020);
        check("jr_mis_pc", pc, 32'h0000_3020);
`endif

        // 5: reset while a request is outstanding, ack in the same cycle
        do_reset("rst2");
        fetch("f3000c", 32'h0000_3000, 32'h0000_0000, 0);
        accept("seq3", 2'b00, 26'd0, 32'd0, 32'h0000_3004);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        rst        = 1'b0;
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_pc", pc, 32'h0000_3000);
        check("midrst_instr", instr, 32'd0);
        check("midrst_req", 32'(imem_req), 32'd0);
        tick();
        check("midrst_valid2", 32'(instr_valid), 32'd0);

        // 6: wrap-around from 0xFFFF_FFFC
        fetch("f3000d", 32'h0000_3000, 32'h0300_0000, 0);
        accept("jr_top", 2'b11, 26'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch("ftop", 32'hFFFF_FFFC, 32'h0000_0000, 1);
        accept("wrap", 2'b00, 26'd0, 32'd0, 32'h0000_0000);
        check("wrap_pc", pc, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
